parking_slot_debounce: RTL and testbench
========================================

// Module: parking_slot_debounce
// PURPOSE
//  Upstream front end for the car-parking occupancy display. Takes 8 raw, asynchronous, bouncy slot sensors.
//  Synchronises and debounces them, producing the stable car[7:0] vector consumed by the 7-segment count stage.
//  Also provides a registered occupied count, full/empty flags, and per-slot arrive/depart event pulses for
//  gate/logging logic.
// PARAMETERS
//  N_SLOTS    8          number of slot sensors (vector width of sensor_raw/car/arrive/depart)
//  CNT_W      4          width of count; must hold N_SLOTS ($clog2(N_SLOTS+1))
//  DB_CYCLES  1000000    consecutive clk cycles a new level must persist to be accepted (10 ms @ 100 MHz); >=1
//  DB_W       20         debounce counter width; must hold DB_CYCLES-1
// PORTS
//  clk         in   1        system clock, all logic on rising edge
//  rst         in   1        asynchronous, active-high reset
//  sensor_raw  in   N_SLOTS  raw slot sensors, 1 = car present, asynchronous to clk
//  car         out  N_SLOTS  debounced slot occupancy, registered
//  count       out  CNT_W    number of 1s in car, registered
//  full        out  1        count == N_SLOTS, registered
//  empty       out  1        count == 0, registered
//  arrive      out  N_SLOTS  1-cycle pulse per slot on accepted 0->1
//  depart      out  N_SLOTS  1-cycle pulse per slot on accepted 1->0
//  changed     out  1        1-cycle pulse, OR of all arrive|depart bits
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - sync flops, debounce counters, car, count, full, arrive, depart and changed all go to 0; empty goes to 1.
//  - Reset never generates arrive/depart pulses, including when asserted mid-debounce.
//  - After release, slots already occupied are re-acquired through the normal debounce path and pulse arrive.
//  Synchroniser: 2-flop chain per bit (s1 <= sensor_raw; s2 <= s1). Only s2 is used downstream.
//  Per-slot debounce, independent for each bit i, evaluated at every clk edge:
//  - s2[i] == car[i]: cnt[i] <= 0.
//  - s2[i] != car[i] and cnt[i] != DB_CYCLES-1: cnt[i] <= cnt[i]+1.
//  - s2[i] != car[i] and cnt[i] == DB_CYCLES-1: car[i] <= s2[i], cnt[i] <= 0, and arrive[i] (or depart[i]) <= 1 for one cycle.
//  - Any single cycle in which s2[i] matches car[i] restarts the qualification window.
//  Latency: edge 1 is the first edge sampling the new raw level; car[i] changes on edge DB_CYCLES+2.
//  A raw pulse shorter than DB_CYCLES cycles is always rejected. Arrive/depart pulses are visible in the
//  same cycle car shows the new value.
//  Count: count <= popcount(car), so count lags car by exactly 1 cycle. full and empty are updated on the
//  same edge from the new count value. Multiple slots flipping in one cycle, in any mix of directions, are
//  resolved in a single update. There is no incremental arithmetic, so count can never drift or wrap.
//  changed is registered alongside arrive/depart, i.e. it equals |(arrive|depart) in the same cycle.
//  No handshake: outputs are level/pulse only. The consumer samples car/count continuously.
// TESTING (run with DB_CYCLES=4, N_SLOTS=8)
//  1. Reset: assert rst mid-debounce of bit 1 -> car=00, count=0, full=0, empty=1 immediately.
//     Release with raw=00 -> no pulses ever.
//  2. Single arrival: raw[0] 0->1 held -> car[0]=1 and arrive=01 (one cycle) on edge 6; changed=1 on edge 6;
//     count=1, empty=0 on edge 7.
//  3. Glitch: raw[3]=1 for 3 cycles then 0 -> car, arrive and count unchanged for 20 cycles.
//  4. Chatter: raw[6] toggles every 2 cycles for 20 cycles, then held 1 -> exactly one arrive[6] pulse,
//     6 edges after the final rise.
//  5. Fill: raw 00->FF in one cycle -> car=FF and arrive=FF for one cycle on edge 6; count=8, full=1 on edge 7.
//     Then raw=FF->00 -> depart=FF, count=0, empty=1.
//  6. Swap: car=20, raw changes to 04 in one cycle -> on edge 6 arrive=04 and depart=20 in the same cycle;
//     count stays 1 throughout.

Source files
------------

// File: rtl/parking_slot_debounce.sv
// -----------------------------------------------------------------------------
// parking_slot_debounce
//
// Front end for the car-parking occupancy display. Eight raw slot sensors
// arrive asynchronously and bounce mechanically. Each bit passes through a
// two-flop synchroniser. It then passes through an independent debounce
// counter before it is accepted into the stable occupancy vector car_o.
// From car_o the block derives:
//   - a registered occupied count
//   - full/empty flags
//   - per-slot arrive/depart event pulses for the gate/logging logic
//
// Ports
//   clk           in   1        system clock, rising edge
//   rst           in   1        asynchronous, active-high reset
//   sensor_raw_i  in   N_SLOTS  raw sensors, 1 = car present, async to clk
//   car_o         out  N_SLOTS  debounced occupancy, registered
//   count_o       out  CNT_W    popcount of car_o, one cycle behind car_o
//   full_o        out  1        count_o == N_SLOTS
//   empty_o       out  1        count_o == 0
//   arrive_o      out  N_SLOTS  one-cycle pulse on accepted 0->1 per slot
//   depart_o      out  N_SLOTS  one-cycle pulse on accepted 1->0 per slot
//   changed_o     out  1        one-cycle pulse, OR of arrive_o | depart_o
// -----------------------------------------------------------------------------
module parking_slot_debounce #(
    parameter int N_SLOTS   = 8,
    parameter int CNT_W     = 4,
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SLOTS-1:0] sensor_raw_i,
    output logic [N_SLOTS-1:0] car_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [N_SLOTS-1:0] arrive_o,
    output logic [N_SLOTS-1:0] depart_o,
    output logic               changed_o
);

    // Terminal count of the qualification window: a new level must be seen
    // on DB_CYCLES consecutive evaluations before it is accepted.
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_SLOTS);

    function automatic logic [CNT_W-1:0] popcount(input logic [N_SLOTS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    logic [N_SLOTS-1:0]           s1_q;
    logic [N_SLOTS-1:0]           s2_q;
    logic [N_SLOTS-1:0][DB_W-1:0] cnt_q;
    logic [N_SLOTS-1:0][DB_W-1:0] cnt_d;
    logic [N_SLOTS-1:0]           car_q;
    logic [N_SLOTS-1:0]           car_d;
    logic [N_SLOTS-1:0]           arrive_q;
    logic [N_SLOTS-1:0]           arrive_d;
    logic [N_SLOTS-1:0]           depart_q;
    logic [N_SLOTS-1:0]           depart_d;
    logic                         changed_q;
    logic                         changed_d;
    logic [CNT_W-1:0]             count_q;
    logic [CNT_W-1:0]             count_d;
    logic                         full_q;
    logic                         full_d;
    logic                         empty_q;
    logic                         empty_d;

    // Per-slot debounce. Any cycle where the synchronised level agrees with
    // the accepted level clears the counter, so only an uninterrupted run of
    // DB_CYCLES disagreeing samples flips car.
    always_comb begin
        car_d    = car_q;
        arrive_d = '0;
        depart_d = '0;
        cnt_d    = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (s2_q[i] != car_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    car_d[i]    = s2_q[i];
                    arrive_d[i] = s2_q[i];
                    depart_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        changed_d = |(arrive_d | depart_d);
    end

    // Count is rebuilt from the registered car vector every cycle rather than
    // tracked incrementally. Simultaneous flips in mixed directions therefore
    // resolve in one update, and the count cannot drift.
    always_comb begin
        count_d = popcount(car_q);
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cnt_q     <= '0;
            car_q     <= '0;
            arrive_q  <= '0;
            depart_q  <= '0;
            changed_q <= 1'b0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            s1_q      <= sensor_raw_i;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            car_q     <= car_d;
            arrive_q  <= arrive_d;
            depart_q  <= depart_d;
            changed_q <= changed_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    assign car_o     = car_q;
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign arrive_o  = arrive_q;
    assign depart_o  = depart_q;
    assign changed_o = changed_q;

endmodule

// File: tb/tb_parking_slot_debounce.sv
// -----------------------------------------------------------------------------
// tb_parking_slot_debounce
//
// Directed bench for parking_slot_debounce with DB_CYCLES = 4.
//   - The stimulus process drives the raw sensors.
//   - For each cycle it cares about, the stimulus pushes the expected
//     output snapshot into a queue, tagged with the absolute edge number.
//   - The monitor samples on every falling edge. It pops the entries due
//     for that edge and compares them.
//   - The monitor also flags any arrive/depart/changed pulse that no entry
//     expected.
// -----------------------------------------------------------------------------
module tb_parking_slot_debounce;

    localparam int N_SLOTS   = 8;
    localparam int CNT_W     = 4;
    localparam int DB_CYCLES = 4;
    localparam int DB_W      = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_SLOTS-1:0] raw = '0;
    logic [N_SLOTS-1:0] car_o;
    logic [CNT_W-1:0]   count_o;
    logic               full_o;
    logic               empty_o;
    logic [N_SLOTS-1:0] arrive_o;
    logic [N_SLOTS-1:0] depart_o;
    logic               changed_o;

    parking_slot_debounce #(
        .N_SLOTS  (N_SLOTS),
        .CNT_W    (CNT_W),
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (DB_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensor_raw_i(raw),
        .car_o       (car_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .arrive_o    (arrive_o),
        .depart_o    (depart_o),
        .changed_o   (changed_o)
    );

    always #5 clk = ~clk;

    // Absolute rising-edge number; edge n is the n-th posedge of clk.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] car;
        logic [7:0] arr;
        logic [7:0] dep;
        logic       chg;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int c, input logic [7:0] car, input logic [7:0] arr,
                             input logic [7:0] dep, input logic [3:0] cnt, input string nm);
        exp_t e;
        e.cyc   = c;
        e.car   = car;
        e.arr   = arr;
        e.dep   = dep;
        e.chg   = |(arr | dep);
        e.cnt   = cnt;
        e.full  = (cnt == 4'd8);
        e.empty = (cnt == 4'd0);
        e.name  = nm;
        q.push_back(e);
    endtask

    // Drive a new raw level just after a rising edge; k is that edge's number,
    // so edge k+1 is the first edge sampling the new level.
    task automatic drive(input logic [7:0] v, output int k);
        @(posedge clk);
        #2;
        raw = v;
        k   = cyc;
    endtask

    // Outputs must stay at (car, cnt) with no pulses for the next n edges.
    task automatic hold(input int n, input logic [7:0] car, input logic [3:0] cnt, input string nm);
        for (int j = 1; j <= n; j++) expect_at(cyc + j, car, 8'h00, 8'h00, cnt, nm);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // A level change applied after edge k: stable through k+5, car and the
    // pulses move on k+6, and count/full/empty follow on k+7.
    task automatic expect_flip(input int k, input logic [7:0] oc, input logic [7:0] nc,
                               input logic [7:0] arr, input logic [7:0] dep,
                               input logic [3:0] ocnt, input logic [3:0] ncnt, input string nm);
        for (int j = 1; j <= 5; j++) expect_at(k + j, oc, 8'h00, 8'h00, ocnt, {nm, "_wait"});
        expect_at(k + 6, nc, arr, dep, ocnt, {nm, "_edge6"});
        expect_at(k + 7, nc, 8'h00, 8'h00, ncnt, {nm, "_edge7"});
        repeat (7) @(posedge clk);
        #2;
    endtask

    task automatic flip(input logic [7:0] v, input logic [7:0] oc, input logic [7:0] nc,
                        input logic [7:0] arr, input logic [7:0] dep,
                        input logic [3:0] ocnt, input logic [3:0] ncnt, input string nm);
        int k;
        drive(v, k);
        expect_flip(k, oc, nc, arr, dep, ocnt, ncnt, nm);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   matched;
        matched = 1'b0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for edge %0d never sampled (now edge %0d)", e.name, e.cyc, cyc);
        end
        while (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            matched = 1'b1;
            checks++;
            if (car_o !== e.car || arrive_o !== e.arr || depart_o !== e.dep ||
                changed_o !== e.chg || count_o !== e.cnt || full_o !== e.full ||
                empty_o !== e.empty) begin
                errors++;
                $display("FAIL %s @edge %0d: got car=%h arr=%h dep=%h chg=%b cnt=%0d full=%b empty=%b, expected car=%h arr=%h dep=%h chg=%b cnt=%0d full=%b empty=%b",
                         e.name, cyc, car_o, arrive_o, depart_o, changed_o, count_o, full_o, empty_o,
                         e.car, e.arr, e.dep, e.chg, e.cnt, e.full, e.empty);
            end
        end
        if (!matched && (changed_o !== 1'b0 || arrive_o !== 8'h00 || depart_o !== 8'h00)) begin
            checks++;
            errors++;
            $display("FAIL spurious_pulse @edge %0d: got arr=%h dep=%h chg=%b, expected no pulse",
                     cyc, arrive_o, depart_o, changed_o);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time (edge %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;

        // Power-up reset state.
        repeat (3) @(posedge clk);
        #2;
        expect_at(cyc, 8'h00, 8'h00, 8'h00, 4'd0, "reset_state");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // 1. Reset asserted mid-debounce of bit 1, released with raw=00.
        drive(8'h02, k);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        raw = 8'h00;
        expect_at(cyc, 8'h00, 8'h00, 8'h00, 4'd0, "rst_mid_debounce");
        hold(2, 8'h00, 4'd0, "rst_held");
        rst = 1'b0;
        hold(20, 8'h00, 4'd0, "after_release_quiet");

        // 2. Single arrival on slot 0.
        flip(8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 4'd0, 4'd1, "arrive0");

        // 3. Three-cycle glitch on slot 3 is rejected.
        drive(8'h09, k);
        for (int j = 1; j <= 3; j++) expect_at(k + j, 8'h01, 8'h00, 8'h00, 4'd1, "glitch3_on");
        repeat (2) @(posedge clk);
        drive(8'h01, k2);
        hold(20, 8'h01, 4'd1, "glitch3_after");

        // 4. Slot 6 chatters every 2 cycles for 20 cycles, then is held high.
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 0) ? 8'h41 : 8'h01, k);
            expect_at(k + 1, 8'h01, 8'h00, 8'h00, 4'd1, "chatter6");
            expect_at(k + 2, 8'h01, 8'h00, 8'h00, 4'd1, "chatter6");
            @(posedge clk);
        end
        flip(8'h41, 8'h01, 8'h41, 8'h40, 8'h00, 4'd1, 4'd2, "chatter6_settle");

        // 5. Clear, then fill all slots in one cycle, then empty them all.
        flip(8'h00, 8'h41, 8'h00, 8'h00, 8'h41, 4'd2, 4'd0, "clear");
        flip(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 4'd0, 4'd8, "fill");
        flip(8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 4'd8, 4'd0, "drain");

        // Reset with a full lot while slot 7 is mid-depart. Reset must clear
        // everything with no pulses; raw=20 held across reset is re-acquired.
        flip(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 4'd0, 4'd8, "refill");
        drive(8'h7F, k);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        raw = 8'h20;
        expect_at(cyc, 8'h00, 8'h00, 8'h00, 4'd0, "rst_full_lot");
        hold(2, 8'h00, 4'd0, "rst_full_held");
        rst = 1'b0;
        expect_flip(cyc, 8'h00, 8'h20, 8'h20, 8'h00, 4'd0, 4'd1, "reacquire5");

        // 6. Swap: slot 5 leaves and slot 2 arrives on the same edge.
        flip(8'h04, 8'h20, 8'h04, 8'h04, 8'h20, 4'd1, 4'd1, "swap");
        hold(10, 8'h04, 4'd1, "swap_after");

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
